// File: rtl/addr_lookup_pipe_pkg.sv
// Shared definitions for the address lookup pipeline: default widths and
// the request record carried from the host side towards the router.
package addr_lookup_pipe_pkg;

  localparam int ADDR_WIDTH     = 64;
  localparam int FLAG_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int MISS_CNT_DEF   = 16;

  // One host request as it travels through the pipe (default payload width).
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      write;
  } req_t;

endpackage

// File: rtl/addr_lookup_pipe_miss_stat_regs.sv
// Miss statistics for the CSR block: saturating drop counter, sticky flag
// and address of the most recent dropped request. A clear pulse wins over
// the counter history but a miss in the same cycle is still recorded.
module miss_stat_regs
  import addr_lookup_pipe_pkg::*;
#(
  parameter int CNT_WIDTH = MISS_CNT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  miss_clr,
  input  logic                  miss_ev,
  input  logic [ADDR_WIDTH-1:0] miss_ev_addr,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic                  miss_sticky,
  output logic [ADDR_WIDTH-1:0] miss_addr
);

  // Counter/sticky update with clear priority; last miss address captured on every miss.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      miss_cnt    <= '0;
      miss_sticky <= 1'b0;
      miss_addr   <= '0;
    end else begin
      if (miss_clr) begin
        miss_cnt    <= miss_ev ? CNT_WIDTH'(1) : '0;
        miss_sticky <= miss_ev;
      end else if (miss_ev) begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        miss_sticky <= 1'b1;
      end
      if (miss_ev) miss_addr <= miss_ev_addr;
    end
  end

endmodule

// File: rtl/addr_lookup_pipe.sv
// Two-stage request pipe in front of the address range comparator.
// S1 registers the request and presents its address for lookup; S2 holds
// the routed request with the comparator flags attached. Misses are dropped
// at S1 and reported to miss_stat_regs.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// valid, once high, stays high with its payload stable until the transfer;
// ready may depend combinationally on the other side (out_ready -> in_ready),
// but valid never depends on ready (no in_valid -> in_ready path).
module addr_lookup_pipe
  import addr_lookup_pipe_pkg::*;
#(
  parameter int FLAG_WIDTH     = FLAG_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MISS_CNT_WIDTH = MISS_CNT_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_write,
  output logic                      cmp_valid,
  output logic [ADDR_WIDTH-1:0]     cmp_addr,
  input  logic                      cmp_hit,
  input  logic [FLAG_WIDTH-1:0]     cmp_flags,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_write,
  output logic [FLAG_WIDTH-1:0]     out_flags,
  input  logic                      miss_clr,
  output logic [MISS_CNT_WIDTH-1:0] miss_cnt,
  output logic                      miss_sticky,
  output logic [ADDR_WIDTH-1:0]     miss_addr
);

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_write;
  logic                  s2_free;
  logic                  s1_retire;
  logic                  s1_fwd;
  logic                  s1_miss;

  // A miss always leaves S1; a hit leaves only when S2 can take it.
  always_comb begin
    s2_free   = ~out_valid | out_ready;
    s1_retire = s1_valid & (~cmp_hit | s2_free);
    s1_fwd    = s1_retire & cmp_hit;
    s1_miss   = s1_retire & ~cmp_hit;
    in_ready  = ~s1_valid | s1_retire;
    cmp_valid = s1_valid;
    cmp_addr  = s1_addr;
  end

  // S1: capture an accepted request; a stalled hit keeps cmp_addr stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_write <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_addr  <= in_addr;
        s1_data  <= in_data;
        s1_write <= in_write;
      end
    end
  end

  // S2: load forwarded hits with their flags, drain on out_ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_write <= 1'b0;
      out_flags <= '0;
    end else if (s1_fwd) begin
      out_valid <= 1'b1;
      out_addr  <= s1_addr;
      out_data  <= s1_data;
      out_write <= s1_write;
      out_flags <= cmp_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  miss_stat_regs #(
    .CNT_WIDTH (MISS_CNT_WIDTH)
  ) u_miss_stat (
    .clk          (clk),
    .reset_n      (reset_n),
    .miss_clr     (miss_clr),
    .miss_ev      (s1_miss),
    .miss_ev_addr (s1_addr),
    .miss_cnt     (miss_cnt),
    .miss_sticky  (miss_sticky),
    .miss_addr    (miss_addr)
  );

endmodule
